// File: rtl/lly_buzzer_ctrl.sv
// Clocked quiz-buzzer arbiter for 16 contestants.
// Grants the first (synchronised) button press, locks out later presses,
// runs a per-round answer countdown, and drives a seven-segment digit,
// a binary winner code and a buzzer strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   key_n      contestant buttons, active-low, asynchronous to clk
//   start      host arms a round (level)
//   clear      host returns to IDLE (level), beats start and presses
//   state      0 IDLE, 1 ARMED, 2 LATCHED, 3 DONE
//   winner     index of granted or fouling contestant
//   winner_vld high in LATCHED
//   foul       high in DONE when caused by a press in IDLE
//   timeout    high in DONE when the countdown expired
//   time_left  remaining seconds, binary
//   seg        time_left digit, active-high, seg[0]=a .. seg[6]=g
//   buzz       buzzer drive
module lly_buzzer_ctrl #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned ANSWER_SEC = 9,
    parameter int unsigned BUZZ_CYC   = 25_000_000,
    parameter bit          FOUL_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_n,
    input  logic        start,
    input  logic        clear,
    output logic [1:0]  state,
    output logic [3:0]  winner,
    output logic        winner_vld,
    output logic        foul,
    output logic        timeout,
    output logic [3:0]  time_left,
    output logic [6:0]  seg,
    output logic        buzz
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned BUZZ_W = $clog2(BUZZ_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LATCHED = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         key_sync1, key_sync2;
    logic [15:0]         press;
    logic                press_any;
    logic [3:0]          press_idx;
    logic                tick;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BUZZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic [3:0]          winner_d, time_left_d;
    logic                winner_vld_d, foul_d, timeout_d, buzz_d;

    // Two-flop synchroniser; idle (released) buttons read as ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync1 <= '1;
            key_sync2 <= '1;
        end else begin
            key_sync1 <= key_n;
            key_sync2 <= key_sync1;
        end
    end

    assign press     = ~key_sync2;
    assign press_any = |press;

    // Highest set index wins: ascending scan, last hit overwrites.
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (press[i]) press_idx = 4'(i);
        end
    end

    assign tick = (state_q == S_ARMED) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            winner     <= '0;
            winner_vld <= 1'b0;
            foul       <= 1'b0;
            timeout    <= 1'b0;
            time_left  <= '0;
            buzz       <= 1'b0;
            tick_cnt_q <= '0;
            buzz_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            winner     <= winner_d;
            winner_vld <= winner_vld_d;
            foul       <= foul_d;
            timeout    <= timeout_d;
            time_left  <= time_left_d;
            buzz       <= buzz_d;
            tick_cnt_q <= tick_cnt_d;
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner;
        winner_vld_d = winner_vld;
        foul_d       = foul;
        timeout_d    = timeout;
        time_left_d  = time_left;
        tick_cnt_d   = tick_cnt_q;
        buzz_d       = buzz;
        buzz_cnt_d   = buzz_cnt_q;

        if (clear) begin
            state_d      = S_IDLE;
            winner_d     = '0;
            winner_vld_d = 1'b0;
            foul_d       = 1'b0;
            timeout_d    = 1'b0;
            time_left_d  = '0;
            tick_cnt_d   = '0;
            buzz_d       = 1'b0;
            buzz_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A press beats start in the same cycle.
                    if (FOUL_EN && press_any) begin
                        state_d  = S_DONE;
                        foul_d   = 1'b1;
                        winner_d = press_idx;
                    end else if (start) begin
                        state_d     = S_ARMED;
                        time_left_d = 4'(ANSWER_SEC);
                        tick_cnt_d  = '0;
                    end
                end
                S_ARMED: begin
                    // A press beats the final tick; countdown freezes.
                    if (press_any) begin
                        state_d      = S_LATCHED;
                        winner_d     = press_idx;
                        winner_vld_d = 1'b1;
                    end else if (tick) begin
                        tick_cnt_d = '0;
                        if (time_left == 4'd1) begin
                            time_left_d = '0;
                            state_d     = S_DONE;
                            timeout_d   = 1'b1;
                        end else begin
                            time_left_d = time_left - 4'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: ;
            endcase

            // Buzz fires once on entry to LATCHED/DONE, then counts down.
            if ((state_q == S_IDLE || state_q == S_ARMED) &&
                (state_d == S_LATCHED || state_d == S_DONE)) begin
                buzz_d     = 1'b1;
                buzz_cnt_d = BUZZ_W'(BUZZ_CYC - 1);
            end else if (buzz) begin
                if (buzz_cnt_q == '0) begin
                    buzz_d = 1'b0;
                end else begin
                    buzz_cnt_d = buzz_cnt_q - BUZZ_W'(1);
                end
            end
        end
    end

    assign state = state_q;

    // Seven-segment decode; blank in IDLE and for values above 9.
    always_comb begin
        seg = '0;
        if (state_q != S_IDLE) begin
            case (time_left)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lly_buzzer_ctrl.sv
// Scoreboard bench for lly_buzzer_ctrl. Stimulus pushes cycle-stamped
// expected output snapshots into a queue; a monitor on the falling edge
// pops each snapshot when its cycle arrives and compares.
module tb_lly_buzzer_ctrl;

    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, LATCHED = 2'd2, DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key_n;
    logic        start, clear;

    logic [1:0]  state_a, state_b;
    logic [3:0]  winner_a, winner_b, tl_a, tl_b;
    logic        vld_a, vld_b, foul_a, foul_b, to_a, to_b, buzz_a, buzz_b;
    logic [6:0]  seg_a, seg_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        string      name;
        bit         sel;      // 0: foul-enabled DUT, 1: foul-disabled DUT
        logic [20:0] vec;     // {state, winner, vld, foul, timeout, time_left, seg, buzz}
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lly_buzzer_ctrl #(.TICK_DIV(4), .ANSWER_SEC(3), .BUZZ_CYC(5), .FOUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .start(start), .clear(clear),
        .state(state_a), .winner(winner_a), .winner_vld(vld_a), .foul(foul_a),
        .timeout(to_a), .time_left(tl_a), .seg(seg_a), .buzz(buzz_a)
    );

    lly_buzzer_ctrl #(.TICK_DIV(4), .ANSWER_SEC(3), .BUZZ_CYC(5), .FOUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .start(start), .clear(clear),
        .state(state_b), .winner(winner_b), .winner_vld(vld_b), .foul(foul_b),
        .timeout(to_b), .time_left(tl_b), .seg(seg_b), .buzz(buzz_b)
    );

    function automatic logic [6:0] seg_of(logic [1:0] st, logic [3:0] tl);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (st == IDLE || tl > 4'd9) return 7'h00;
        return tbl[tl];
    endfunction

    // Insert an expectation keeping the queue sorted by cycle.
    function automatic void push_exp(int c, string n, bit sel, logic [1:0] st, logic [3:0] win,
                                     logic vld, logic fl, logic to, logic [3:0] tl, logic bz);
        exp_t e;
        int i;
        e.cyc = c;
        e.name = n;
        e.sel = sel;
        e.vec = {st, win, vld, fl, to, tl, seg_of(st, tl), bz};
        i = q.size();
        while (i > 0 && q[i-1].cyc > c) i--;
        q.insert(i, e);
    endfunction

    function automatic logic [20:0] act_vec(bit sel);
        if (sel) return {state_b, winner_b, vld_b, foul_b, to_b, tl_b, seg_b, buzz_b};
        return {state_a, winner_a, vld_a, foul_a, to_a, tl_a, seg_a, buzz_a};
    endfunction

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [20:0] a;
            e = q.pop_front();
            a = act_vec(e.sel);
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (a !== e.vec) begin
                n_fail++;
                $display("FAIL %s @%0d: got st=%0d win=%0d vld=%b foul=%b to=%b tl=%0d seg=%h buzz=%b, want st=%0d win=%0d vld=%b foul=%b to=%b tl=%0d seg=%h buzz=%b",
                         e.name, cyc, a[20:19], a[18:15], a[14], a[13], a[12], a[11:8], a[7:1], a[0],
                         e.vec[20:19], e.vec[18:15], e.vec[14], e.vec[13], e.vec[12], e.vec[11:8], e.vec[7:1], e.vec[0]);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n = 1'b0;
        key_n = '1;
        start = 1'b0;
        clear = 1'b0;
        step(2);
        push_exp(cyc + 1, "reset_a", 0, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        push_exp(cyc + 1, "reset_b", 1, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Foul in IDLE: key 7 low; FOUL_EN=0 instance must stay IDLE.
        s = cyc;
        key_n[7] = 1'b0;
        push_exp(s + 2, "foul_pre",   0, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        push_exp(s + 3, "foul_done",  0, DONE, 4'd7, 0, 1, 0, 4'd0, 1);
        push_exp(s + 3, "nofoul_idle", 1, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        push_exp(s + 7, "foul_buzz_last", 0, DONE, 4'd7, 0, 1, 0, 4'd0, 1);
        push_exp(s + 8, "foul_buzz_off",  0, DONE, 4'd7, 0, 1, 0, 4'd0, 0);
        step(4);
        key_n = '1;
        step(5);
        clear = 1'b1;
        push_exp(cyc + 1, "foul_clear", 0, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        step(1);

        // Countdown to timeout, no keys.
        clear = 1'b0;
        start = 1'b1;
        s = cyc;
        push_exp(s + 1,  "to_t3",     0, ARMED, 4'd0, 0, 0, 0, 4'd3, 0);
        push_exp(s + 4,  "to_t3_end", 0, ARMED, 4'd0, 0, 0, 0, 4'd3, 0);
        push_exp(s + 5,  "to_t2",     0, ARMED, 4'd0, 0, 0, 0, 4'd2, 0);
        push_exp(s + 9,  "to_t1",     0, ARMED, 4'd0, 0, 0, 0, 4'd1, 0);
        push_exp(s + 12, "to_t1_end", 0, ARMED, 4'd0, 0, 0, 0, 4'd1, 0);
        push_exp(s + 13, "to_done",   0, DONE,  4'd0, 0, 0, 1, 4'd0, 1);
        push_exp(s + 17, "to_buzz_last", 0, DONE, 4'd0, 0, 0, 1, 4'd0, 1);
        push_exp(s + 18, "to_buzz_off",  0, DONE, 4'd0, 0, 0, 1, 4'd0, 0);
        step(1);
        start = 1'b0;
        step(18);
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // Grant key 5; later key 12 is locked out; countdown frozen.
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
        key_n[5] = 1'b0;
        push_exp(s + 3,  "lat_pre",    0, ARMED,   4'd0, 0, 0, 0, 4'd3, 0);
        push_exp(s + 4,  "lat_k5",     0, LATCHED, 4'd5, 1, 0, 0, 4'd3, 1);
        push_exp(s + 12, "lat_hold",   0, LATCHED, 4'd5, 1, 0, 0, 4'd3, 0);
        push_exp(s + 14, "lat_clear",  0, IDLE,    4'd0, 0, 0, 0, 4'd0, 0);
        step(4);
        key_n[12] = 1'b0;
        step(5);
        key_n = '1;
        step(3);
        clear = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        step(1);

        // Simultaneous keys 3 and 11: highest index wins.
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
        key_n[3] = 1'b0;
        key_n[11] = 1'b0;
        push_exp(s + 4, "prio_11", 0, LATCHED, 4'd11, 1, 0, 0, 4'd3, 1);
        step(4);
        key_n = '1;
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // Key 0 press lands on the final tick: LATCHED wins, time_left stays 1.
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
        push_exp(s + 12, "coin_pre",   0, ARMED,   4'd0, 0, 0, 0, 4'd1, 0);
        push_exp(s + 13, "coin_latch", 0, LATCHED, 4'd0, 1, 0, 0, 4'd1, 1);
        step(9);
        key_n[0] = 1'b0;
        step(4);
        key_n = '1;
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // Asynchronous reset mid-ARMED.
        start = 1'b1;
        s = cyc;
        push_exp(s + 5, "rst_pre", 0, ARMED, 4'd0, 0, 0, 0, 4'd2, 0);
        step(1);
        start = 1'b0;
        step(4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_exp(cyc, "rst_async", 0, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        step(2);
        rst_n = 1'b1;
        push_exp(cyc + 1, "rst_after", 0, IDLE, 4'd0, 0, 0, 0, 4'd0, 0);
        step(3);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
